fetch_prefetch_arbiter: RTL and testbench
=========================================

// Module: fetch_prefetch_arbiter
// PURPOSE
//  Sits directly upstream of the unified single-port instruction/data memory. Owns its only port.
//  Arbitrates per cycle between MEM-stage data accesses (always win) and instruction fetch.
//  Fetches into a small prefetch FIFO, so loads/stores rarely starve IF.
//  Presents the FIFO head to the IF stage as a valid/ready stream. Handles branch redirect flush.
// PARAMETERS
//  DEPTH     4    prefetch FIFO entries; power of 2, >=2
//  RESET_PC  0    byte address of first fetch after reset
// PORTS
//  clk           in   1   system clock, rising edge
//  rst           in   1   asynchronous reset, active-high
//  redirect      in   1   taken branch/jump: flush FIFO, refetch from redirect_pc
//  redirect_pc   in   32  new fetch address (word aligned)
//  if_ready      in   1   IF stage consumes FIFO head this cycle
//  if_valid      out  1   FIFO head valid
//  if_instr      out  32  head instruction; 32'h00000013 (NOP) when !if_valid
//  if_pc         out  32  byte address of head instruction; 0 when !if_valid
//  dm_read       in   1   MEM-stage load request
//  dm_write      in   1   MEM-stage store request (dm_read&dm_write never both 1)
//  dm_func3      in   3   RV32 load/store width code (0 b, 1 h, 2 w, 4 bu, 5 hu)
//  dm_addr       in   32  data byte address
//  dm_wdata      in   32  store data
//  dm_rdata      out  32  load data, combinational from mem_rdata; 0 if not a granted load
//  dm_misalign   out  1   comb: (h/hu & addr[0]) | (w & addr[1:0]!=0), qualified by dm_read|dm_write
//  mem_read      out  1   to memory
//  mem_write     out  1   to memory
//  mem_func3     out  3   to memory
//  mem_addr      out  32  to memory
//  mem_wdata     out  32  to memory
//  mem_rdata     in   32  from memory, combinational read of mem_addr
// BEHAVIOUR
//  - Reset (async): FIFO count/pointers=0, pf_addr=RESET_PC, if_valid=0, if_instr=NOP, if_pc=0.
//  - Port grant each cycle, comb:
//    DATA  if (dm_read|dm_write)&!dm_misalign: mem_* = dm_*; no fetch this cycle.
//    FETCH else if count<DEPTH & !redirect: mem_read=0, mem_write=0, mem_func3=3'b010,
//          mem_addr={pf_addr[31:2],2'b00}; mem_rdata pushed with pf_addr at clk edge; pf_addr+=4 (mod 2^32).
//    IDLE  else: same drive as FETCH, no push, pf_addr held.
//  - Misaligned access: never reaches memory (mem_write=0), dm_rdata=0. The port is free, so fetch may proceed.
//  - Fetch-to-IF latency: 1 cycle. A word fetched in cycle N is at head/if_valid after edge N (if FIFO was empty).
//  - Pop on if_valid&if_ready; push+pop same cycle: count unchanged.
//  - Full: no fetch, pf_addr held. Empty: if_valid=0 and pop ignored.
//  - redirect priority over push/pop: at edge, count=0, pointers=0, pf_addr=redirect_pc.
//    The fetch word in that cycle is discarded. The next cycle fetches redirect_pc.
//    A data access in the redirect cycle is still serviced.
//  - Counters are $clog2(DEPTH)+1 bits; pointers wrap mod DEPTH.
//  - Reset mid-operation: FIFO contents discarded; any in-flight store not forwarded after rst asserts.
// CONFIGURATION
//  PF_STATS_EN defined: adds outputs stat_starve[31:0] and stat_data[31:0], both reset to 0, saturating.
//    stat_starve counts cycles with if_ready & !if_valid & !redirect.
//    stat_data counts DATA grant cycles.
//  PF_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 rst pulse, mem words 0..3 at 0,4,8,12, if_ready=1 -> if_pc 0,4,8 on consecutive cycles from 1st edge.
//  2 if_ready=0, DEPTH=4 -> count saturates at 4, pf_addr=16 and held; if_pc stays 0.
//  3 dm_read=1, func3=2, addr=100, mem[100]=17 -> mem_addr=100, dm_rdata=17 same cycle, no push, pf_addr unchanged.
//  4 Three entries queued, redirect=1, redirect_pc=0x20 -> next cycle if_valid=0; following cycle if_pc=0x20.
//  5 dm_write=1, func3=1, addr=0x65 -> dm_misalign=1, mem_write=0, memory unchanged, fetch proceeds.
//  6 count=1, dm_write=1 (aligned sw), if_ready=1 -> store forwarded, count 0, if_valid=0 next cycle.
//  7 PF_STATS_EN defined: repeat 6 -> stat_data=1, then stat_starve increments each starved cycle.

Source files
------------

// File: rtl/fetch_prefetch_arbiter.sv
// Single-port memory arbiter: MEM-stage data accesses win, instruction fetch fills a small
// prefetch FIFO presented to IF as valid/ready. Optional macro PF_STATS_EN adds stat counters.
module fetch_prefetch_arbiter #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        if_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        dm_read,
  input  logic        dm_write,
  input  logic [2:0]  dm_func3,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_misalign,
  output logic        mem_read,
  output logic        mem_write,
  output logic [2:0]  mem_func3,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef PF_STATS_EN
  ,
  output logic [31:0] stat_starve,
  output logic [31:0] stat_data
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   r_instr [DEPTH];
  logic [31:0]   r_pc    [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic [31:0]   r_pfAddr;

  logic w_anyReq;
  logic w_misalign;
  logic w_dataGrant;
  logic w_full;
  logic w_push;
  logic w_pop;
  logic w_valid;

  assign w_anyReq   = dm_read | dm_write;
  assign w_misalign = w_anyReq &
                      ((((dm_func3 == 3'd1) | (dm_func3 == 3'd5)) & dm_addr[0]) |
                       ((dm_func3 == 3'd2) & (dm_addr[1:0] != 2'b00)));
  // A store caught by reset must never reach memory, so the grant is killed while rst is high.
  assign w_dataGrant = w_anyReq & ~w_misalign & ~rst;
  assign w_full      = (r_count == CW'(DEPTH));
  assign w_push      = ~w_dataGrant & ~w_full & ~redirect;
  assign w_valid     = (r_count != '0);
  assign w_pop       = w_valid & if_ready;

  assign dm_misalign = w_misalign;
  assign dm_rdata    = (w_dataGrant & dm_read) ? mem_rdata : 32'h0;
  assign if_valid    = w_valid;
  assign if_instr    = w_valid ? r_instr[r_rptr] : NOP;
  assign if_pc       = w_valid ? r_pc[r_rptr] : 32'h0;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_func3 = 3'b010;
    mem_addr  = {r_pfAddr[31:2], 2'b00};
    mem_wdata = 32'h0;
    if (w_dataGrant) begin
      mem_read  = dm_read;
      mem_write = dm_write;
      mem_func3 = dm_func3;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr[r_wptr] <= mem_rdata;
      r_pc[r_wptr]    <= r_pfAddr;
    end
  end

  // Redirect outranks push and pop: the word fetched in the redirect cycle is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_pfAddr <= RESET_PC;
    end else if (redirect) begin
      r_count  <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_pfAddr <= redirect_pc;
    end else begin
      if (w_push) begin
        r_wptr   <= r_wptr + PW'(1);
        r_pfAddr <= r_pfAddr + 32'd4;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      if (w_push & ~w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (~w_push & w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

`ifdef PF_STATS_EN
  logic [31:0] r_statStarve;
  logic [31:0] r_statData;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_statStarve <= 32'h0;
      r_statData   <= 32'h0;
    end else begin
      if (if_ready & ~w_valid & ~redirect & (r_statStarve != 32'hFFFF_FFFF)) begin
        r_statStarve <= r_statStarve + 32'd1;
      end
      if (w_dataGrant & (r_statData != 32'hFFFF_FFFF)) begin
        r_statData <= r_statData + 32'd1;
      end
    end
  end

  assign stat_starve = r_statStarve;
  assign stat_data   = r_statData;
`endif

endmodule

// File: tb/tb_fetch_prefetch_arbiter.sv
// Scoreboard bench for fetch_prefetch_arbiter: stimulus queues expected IF words and data-port
// responses, a negedge monitor pops and compares them; directed checks cover reset and boundaries.
module tb_fetch_prefetch_arbiter;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        dm_read;
  logic        dm_write;
  logic [2:0]  dm_func3;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_misalign;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  mem_func3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
`ifdef PF_STATS_EN
  logic [31:0] stat_starve;
  logic [31:0] stat_data;
`endif

  typedef struct {
    logic        misalign;
    logic [31:0] rdata;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dataExp_t;

  logic [31:0] expIfQ [$];
  dataExp_t    expDataQ [$];
  logic [31:0] mem [1024];
  int          numCompared;
  int          numMismatched;
  int          ifPops;

  fetch_prefetch_arbiter #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_ready(if_ready), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .dm_read(dm_read), .dm_write(dm_write), .dm_func3(dm_func3), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_misalign(dm_misalign),
    .mem_read(mem_read), .mem_write(mem_write), .mem_func3(mem_func3),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef PF_STATS_EN
    , .stat_starve(stat_starve), .stat_data(stat_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial memory image: word i holds A000_0000+i, except word 25 (byte 100) holds 17.
  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a[11:2] == 10'd25) return 32'd17;
    return 32'hA000_0000 + {22'b0, a[11:2]};
  endfunction

  assign mem_rdata = mem[mem_addr[11:2]];

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = memval(32'(i) << 2);
    forever begin
      @(posedge clk);
      if (mem_write) begin
        case (mem_func3)
          3'd0: case (mem_addr[1:0])
                  2'd0: mem[mem_addr[11:2]][7:0]   <= mem_wdata[7:0];
                  2'd1: mem[mem_addr[11:2]][15:8]  <= mem_wdata[7:0];
                  2'd2: mem[mem_addr[11:2]][23:16] <= mem_wdata[7:0];
                  default: mem[mem_addr[11:2]][31:24] <= mem_wdata[7:0];
                endcase
          3'd1: if (mem_addr[1]) mem[mem_addr[11:2]][31:16] <= mem_wdata[15:0];
                else             mem[mem_addr[11:2]][15:0]  <= mem_wdata[15:0];
          default: mem[mem_addr[11:2]] <= mem_wdata;
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    numCompared++;
    if (act !== exp) begin
      numMismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic rdy,
                               input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd);
    @(posedge clk);
    #1;
    redirect    = redir;
    redirect_pc = rpc;
    if_ready    = rdy;
    dm_read     = rd;
    dm_write    = wr;
    dm_func3    = f3;
    dm_addr     = addr;
    dm_wdata    = wd;
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 32'h0, rdy, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
  endtask

  task automatic pushStream(input logic [31:0] start, input int n);
    expIfQ.delete();
    for (int i = 0; i < n; i++) expIfQ.push_back(start + 32'(i * 4));
  endtask

  task automatic pushData(input logic mis, input logic [31:0] rdata, input logic rd,
                          input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    dataExp_t e;
    e.misalign = mis;
    e.rdata    = rdata;
    e.rd       = rd;
    e.wr       = wr;
    e.addr     = addr;
    e.wdata    = wd;
    expDataQ.push_back(e);
  endtask

  // Monitor: compares the IF stream on every handshake and the memory port on every data request.
  always @(negedge clk) begin
    if (!rst) begin
      if (if_valid && if_ready) begin
        if (expIfQ.size() == 0) begin
          numCompared++;
          numMismatched++;
          $display("[TB] FAIL ifUnexpected: got pc %h expected no handshake", if_pc);
        end else begin
          logic [31:0] e;
          e = expIfQ.pop_front();
          checkOutput("ifPc", if_pc, e);
          checkOutput("ifInstr", if_instr, memval(e));
          ifPops++;
        end
      end
      if (dm_read || dm_write) begin
        if (expDataQ.size() == 0) begin
          numCompared++;
          numMismatched++;
          $display("[TB] FAIL dataUnexpected: got addr %h expected no request", dm_addr);
        end else begin
          dataExp_t d;
          d = expDataQ.pop_front();
          checkOutput("dmMisalign", {31'b0, dm_misalign}, {31'b0, d.misalign});
          checkOutput("dmRdata", dm_rdata, d.rdata);
          checkOutput("memRead", {31'b0, mem_read}, {31'b0, d.rd});
          checkOutput("memWrite", {31'b0, mem_write}, {31'b0, d.wr});
          checkOutput("memAddr", mem_addr, d.addr);
          if (d.wr) checkOutput("memWdata", mem_wdata, d.wdata);
        end
      end
    end
  end

  initial begin
    numCompared   = 0;
    numMismatched = 0;
    ifPops        = 0;
    rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; if_ready = 1'b0;
    dm_read = 1'b0; dm_write = 1'b0; dm_func3 = 3'd2; dm_addr = 32'h0; dm_wdata = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rstValid", {31'b0, if_valid}, 32'd0);
    checkOutput("rstInstr", if_instr, NOP);
    checkOutput("rstPc", if_pc, 32'h0);
    checkOutput("rstAddr", mem_addr, 32'h0);

    pushStream(32'h0, 8);
    idle(1'b1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("firstValid", {31'b0, if_valid}, 32'd0);
    checkOutput("firstAddr", mem_addr, 32'h0);
    checkOutput("firstFunc3", {29'b0, mem_func3}, 32'd2);
`ifdef PF_STATS_EN
    checkOutput("statDataRst", stat_data, 32'd0);
    checkOutput("statStarveRst", stat_starve, 32'd0);
`endif

    repeat (4) idle(1'b1);
    repeat (3) idle(1'b0);
    idle(1'b0);
    @(negedge clk);
    checkOutput("fullValid", {31'b0, if_valid}, 32'd1);
    checkOutput("fullPc", if_pc, 32'd16);
    checkOutput("fullAddr", mem_addr, 32'd32);
    repeat (2) idle(1'b0);
    @(negedge clk);
    checkOutput("fullHeld", mem_addr, 32'd32);

    pushData(1'b0, 32'd17, 1'b1, 1'b0, 32'd100, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 3'd2, 32'd100, 32'h0);
    idle(1'b1);
    @(negedge clk);
    checkOutput("pfKept", mem_addr, 32'd32);

    pushData(1'b0, memval(32'h48), 1'b1, 1'b0, 32'h48, 32'h0);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 3'd2, 32'h48, 32'h0);
    idle(1'b1);
    pushStream(32'h40, 4);
    @(negedge clk);
    checkOutput("redirValid", {31'b0, if_valid}, 32'd0);
    checkOutput("redirAddr", mem_addr, 32'h40);
    idle(1'b1);
    @(negedge clk);
    checkOutput("redirPc", if_pc, 32'h40);

    pushData(1'b1, 32'h0, 1'b0, 1'b0, 32'h48, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 3'd1, 32'h65, 32'h0000_1234);
    pushData(1'b0, 32'h0, 1'b0, 1'b1, 32'h800, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 3'd2, 32'h800, 32'hDEAD_BEEF);
    idle(1'b1);
    @(negedge clk);
    checkOutput("drainValid", {31'b0, if_valid}, 32'd0);
    checkOutput("drainAddr", mem_addr, 32'h4C);
    checkOutput("storeDone", mem[512], 32'hDEAD_BEEF);
    checkOutput("misalignNoWrite", mem[25], 32'd17);
    idle(1'b1);

    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 3'd2, 32'h804, 32'h0000_0055);
    #2;
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midRstWrite", {31'b0, mem_write}, 32'd0);
    checkOutput("midRstValid", {31'b0, if_valid}, 32'd0);
    checkOutput("midRstInstr", if_instr, NOP);
    checkOutput("midRstAddr", mem_addr, 32'h0);

    pushStream(32'h0, 3);
    idle(1'b1);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reFirstValid", {31'b0, if_valid}, 32'd0);
    repeat (3) idle(1'b1);
    idle(1'b0);
    @(negedge clk);
    checkOutput("rstStoreDropped", mem[513], memval(32'h804));
    checkOutput("dataQDrained", 32'(expDataQ.size()), 32'd0);
    checkOutput("ifPops", 32'(ifPops), 32'd13);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
